noc_vc_fifo: RTL and testbench
==============================

# noc_vc_fifo

Multi-virtual-channel input buffer for the NoC router input port. It holds NUM_VC independent FIFOs, each DEPTH flits deep, behind one shared write port and one shared read port, and adds packet awareness (complete-packet detection) beyond the single-queue FIFO. It sits between the link receiver and the router's VC allocator / crossbar, and is a drop-in generalisation of the single-queue router FIFO.

## Interface
- DATA_WIDTH, 32: flit width; [DATA_WIDTH-1:DATA_WIDTH-3] flit type, [DATA_WIDTH-4:1] data, [0] parity
- DEPTH, 4: flits per VC; power of two, ≥2
- NUM_VC, 2: number of virtual channels, ≥2
- VC_IDX_W, 1: VC select width, = clog2(NUM_VC)

- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- wr_en  in  1  write request
- wr_vc  in  VC_IDX_W  target VC of write
- data_in  in  DATA_WIDTH  flit to write
- rd_en  in  1  read (pop) request
- rd_vc  in  VC_IDX_W  VC to read / present on data_out
- data_out  out  DATA_WIDTH  head flit of VC rd_vc (first-word fall-through)
- empty  out  NUM_VC  per-VC empty
- ready_out  out  NUM_VC  per-VC space available (count < DEPTH)
- pkt_avail  out  NUM_VC  per-VC: at least one TAIL flit stored
- err_ovf  out  1  sticky: write to full VC attempted
- err_udf  out  1  sticky: read of empty VC attempted
- parity_err  out  1  sticky parity error (see Configuration)

## Operation
- Flit type codes: HEADER 3'b001, PAYLOAD 3'b010, TAIL 3'b100.
- Per VC: write pointer, read pointer (log2(DEPTH) bits, wrap modulo DEPTH), count (log2(DEPTH)+1 bits, 0..DEPTH), tail_cnt (log2(DEPTH)+1 bits).
- Write accepted iff wr_en && count[wr_vc] < DEPTH, with count sampled before this edge. A concurrent read from the same VC does not make room in the same cycle. Accepted: store at wr_ptr, wr_ptr+1, count+1. Rejected: storage unchanged, err_ovf set.
- Read accepted iff rd_en && count[rd_vc] > 0. Accepted: rd_ptr+1, count-1. Rejected: err_udf set, no state change.
- Same VC, both accepted: pointers both advance, count unchanged. Different VCs: fully independent.
- tail_cnt[v]: +1 on an accepted write of a TAIL flit, -1 on an accepted read of a TAIL flit; both at once leaves it unchanged. pkt_avail[v] = tail_cnt[v] != 0.
- data_out = mem[rd_vc][rd_ptr[rd_vc]] when !empty[rd_vc], else 0.
- err_ovf, err_udf, parity_err: sticky, cleared only by rst.
- Out-of-range wr_vc/rd_vc (≥NUM_VC) is treated as a rejected request of the matching kind and sets the matching error flag.

## Timing
- Write-to-visible latency: 1 cycle. A flit written at edge N is on data_out (if selected) and empty deasserts after edge N.
- empty, ready_out, pkt_avail: combinational from registered count/tail_cnt, so they update after each edge. No decode of current-cycle requests.
- data_out: combinational from rd_vc and registered state, valid the same cycle rd_vc changes.
- Reset values: empty all 1, ready_out all 1, pkt_avail all 0, data_out 0, err_ovf/err_udf/parity_err 0. Pointers, counts and tail_cnt go to 0.
- Reset mid-operation: all queued flits are discarded immediately (asynchronous). Storage array contents are not cleared but are unreachable.
- Throughput: one write and one read per cycle sustained.

## Configuration
- PARITY_CHECK_EN defined: on each accepted write, parity_err is set if the XOR over all DATA_WIDTH bits of data_in is 1 (even parity expected). The flit is stored regardless.
- PARITY_CHECK_EN undefined: no parity logic is built and parity_err is tied to 0.

## Test plan
- Reset with DEPTH=4, NUM_VC=2 -> empty=2'b11, ready_out=2'b11, pkt_avail=0, data_out=0, all errors 0.
- Write HEADER, PAYLOAD, PAYLOAD, TAIL to VC0, then one more write to VC0 -> ready_out[0]=0 after 4th edge, pkt_avail[0]=1, 5th write dropped, err_ovf=1, VC1 still empty.
- Interleave writes VC0/VC1 with rd_vc=1 -> data_out shows VC1 head only, VC0 order preserved, each VC pops in FIFO order across pointer wrap (≥6 push/pop pairs).
- VC0 full + simultaneous write and read on VC0 -> read accepted, write dropped, count 3, err_ovf=1. VC0 empty + simultaneous write and read -> write accepted, count 1, err_udf=1.
- Pop the TAIL from VC0 holding one packet -> pkt_avail[0] falls after that edge. Assert rst mid-packet -> all flags return to reset values without waiting for a clk edge.
- With PARITY_CHECK_EN, write 32'h0000_0001 -> parity_err=1 and the flit is stored. Without the macro -> parity_err stays 0.

Source files
------------

// File: rtl/noc_vc_fifo.sv
// Multi-VC input buffer: NUM_VC independent FWFT queues behind one write and one read port, with per-VC TAIL counting.
// Optional PARITY_CHECK_EN adds a sticky even-parity check on accepted writes; otherwise parity_err is tied low.
module noc_vc_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int NUM_VC     = 2,
  parameter int VC_IDX_W   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [VC_IDX_W-1:0]   wr_vc,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  rd_en,
  input  logic [VC_IDX_W-1:0]   rd_vc,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [NUM_VC-1:0]     empty,
  output logic [NUM_VC-1:0]     ready_out,
  output logic [NUM_VC-1:0]     pkt_avail,
  output logic                  err_ovf,
  output logic                  err_udf,
  output logic                  parity_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [2:0] TYPE_TAIL = 3'b100;

  logic [DATA_WIDTH-1:0] mem_q [NUM_VC][DEPTH];
  logic [PW-1:0] wr_ptr_q [NUM_VC];
  logic [PW-1:0] wr_ptr_d [NUM_VC];
  logic [PW-1:0] rd_ptr_q [NUM_VC];
  logic [PW-1:0] rd_ptr_d [NUM_VC];
  logic [CW-1:0] count_q  [NUM_VC];
  logic [CW-1:0] count_d  [NUM_VC];
  logic [CW-1:0] tail_q   [NUM_VC];
  logic [CW-1:0] tail_d   [NUM_VC];
  logic          ovf_q, ovf_d, udf_q, udf_d;

  logic                  wr_vc_ok, rd_vc_ok, wr_ok, rd_ok, rd_has;
  logic                  wr_tail, rd_tail;
  logic [DATA_WIDTH-1:0] head;

  // Out-of-range VC selects fall through to rejection and raise the error flag.
  assign wr_vc_ok = (32'(wr_vc) < NUM_VC);
  assign rd_vc_ok = (32'(rd_vc) < NUM_VC);
  assign wr_ok    = wr_en && wr_vc_ok && (count_q[wr_vc] != FULL);
  assign rd_has   = rd_vc_ok && (count_q[rd_vc] != '0);
  assign rd_ok    = rd_en && rd_has;
  assign head     = mem_q[rd_vc][rd_ptr_q[rd_vc]];
  assign data_out = rd_has ? head : '0;
  assign wr_tail  = (data_in[DATA_WIDTH-1 -: 3] == TYPE_TAIL);
  assign rd_tail  = (head[DATA_WIDTH-1 -: 3] == TYPE_TAIL);

  always_comb begin
    for (int v = 0; v < NUM_VC; v++) begin
      logic w, r;
      w = wr_ok && (wr_vc == VC_IDX_W'(v));
      r = rd_ok && (rd_vc == VC_IDX_W'(v));
      wr_ptr_d[v] = wr_ptr_q[v] + (w ? PW'(1) : PW'(0));
      rd_ptr_d[v] = rd_ptr_q[v] + (r ? PW'(1) : PW'(0));
      count_d[v]  = count_q[v] + CW'(w) - CW'(r);
      tail_d[v]   = tail_q[v] + CW'(w && wr_tail) - CW'(r && rd_tail);
    end
    ovf_d = ovf_q | (wr_en & ~wr_ok);
    udf_d = udf_q | (rd_en & ~rd_ok);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int v = 0; v < NUM_VC; v++) begin
        wr_ptr_q[v] <= '0;
        rd_ptr_q[v] <= '0;
        count_q[v]  <= '0;
        tail_q[v]   <= '0;
      end
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      for (int v = 0; v < NUM_VC; v++) begin
        wr_ptr_q[v] <= wr_ptr_d[v];
        rd_ptr_q[v] <= rd_ptr_d[v];
        count_q[v]  <= count_d[v];
        tail_q[v]   <= tail_d[v];
      end
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  // Storage is not reset; cleared pointers make stale entries unreachable.
  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_vc][wr_ptr_q[wr_vc]] <= data_in;
  end

  always_comb begin
    for (int v = 0; v < NUM_VC; v++) begin
      empty[v]     = (count_q[v] == '0);
      ready_out[v] = (count_q[v] != FULL);
      pkt_avail[v] = (tail_q[v] != '0);
    end
  end

  assign err_ovf = ovf_q;
  assign err_udf = udf_q;

`ifdef PARITY_CHECK_EN
  logic par_q, par_d;
  assign par_d = par_q | (wr_ok & (^data_in));
  always_ff @(posedge clk or posedge rst) begin
    if (rst) par_q <= 1'b0;
    else     par_q <= par_d;
  end
  assign parity_err = par_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_noc_vc_fifo.sv
// Directed bench for noc_vc_fifo: queue-based reference model checked every negedge, plus literal spot checks.
module tb_noc_vc_fifo;
  localparam int DW = 32;
  localparam int DEPTH = 4;
  localparam int NVC = 2;
  localparam logic [2:0] T_HDR = 3'b001, T_PAY = 3'b010, T_TAIL = 3'b100;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en, rd_en;
  logic [0:0]    wr_vc, rd_vc;
  logic [DW-1:0] data_in, data_out;
  logic [NVC-1:0] empty, ready_out, pkt_avail;
  logic          err_ovf, err_udf, parity_err;

  noc_vc_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .NUM_VC(NVC), .VC_IDX_W(1)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_vc(wr_vc), .data_in(data_in),
    .rd_en(rd_en), .rd_vc(rd_vc), .data_out(data_out), .empty(empty),
    .ready_out(ready_out), .pkt_avail(pkt_avail), .err_ovf(err_ovf),
    .err_udf(err_udf), .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  bit chk_on = 1'b0;

  logic [DW-1:0] q0[$];
  logic [DW-1:0] q1[$];
  bit m_ovf, m_udf, m_par;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] mk(input logic [2:0] t, input logic [27:0] d);
    logic [DW-1:0] f;
    f = {t, d, 1'b0};
    f[0] = ^f;
    return f;
  endfunction

  function automatic int qsize(input int v);
    return (v == 0) ? q0.size() : q1.size();
  endfunction

  function automatic logic [DW-1:0] qhead(input int v);
    if (qsize(v) == 0) return '0;
    return (v == 0) ? q0[0] : q1[0];
  endfunction

  function automatic int tails(input int v);
    int n = 0;
    for (int i = 0; i < qsize(v); i++)
      if (((v == 0) ? q0[i][DW-1 -: 3] : q1[i][DW-1 -: 3]) == T_TAIL) n++;
    return n;
  endfunction

  task automatic model_reset();
    q0.delete(); q1.delete();
    m_ovf = 0; m_udf = 0; m_par = 0;
  endtask

  // Apply one clock edge's worth of requests using the pre-edge occupancy.
  task automatic model_step();
    bit wa, ra;
    if (rst) return;
    wa = wr_en && (qsize(int'(wr_vc)) < DEPTH);
    ra = rd_en && (qsize(int'(rd_vc)) > 0);
    if (ra) begin
      if (rd_vc == 0) void'(q0.pop_front()); else void'(q1.pop_front());
    end
    if (wa) begin
      if (wr_vc == 0) q0.push_back(data_in); else q1.push_back(data_in);
    end
    if (wr_en && !wa) m_ovf = 1;
    if (rd_en && !ra) m_udf = 1;
`ifdef PARITY_CHECK_EN
    if (wa && (^data_in)) m_par = 1;
`endif
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      chk("data_out", data_out, qhead(int'(rd_vc)));
      for (int v = 0; v < NVC; v++) begin
        chk("empty", 32'(empty[v]), 32'(qsize(v) == 0));
        chk("ready_out", 32'(ready_out[v]), 32'(qsize(v) < DEPTH));
        chk("pkt_avail", 32'(pkt_avail[v]), 32'(tails(v) != 0));
      end
      chk("err_ovf", 32'(err_ovf), 32'(m_ovf));
      chk("err_udf", 32'(err_udf), 32'(m_udf));
      chk("parity_err", 32'(parity_err), 32'(m_par));
    end
  end

  task automatic cyc(input bit we, input int wv, input logic [DW-1:0] d,
                     input bit re, input int rv);
    wr_en = we; wr_vc = 1'(wv); data_in = d; rd_en = re; rd_vc = 1'(rv);
    @(posedge clk);
    model_step();
    #1;
  endtask

  initial begin
    rst = 1'b1; wr_en = 0; rd_en = 0; wr_vc = 0; rd_vc = 0; data_in = '0;
    model_reset();
    #12;
    chk("rst_empty", 32'(empty), 32'h3);
    chk("rst_ready", 32'(ready_out), 32'h3);
    chk("rst_pkt", 32'(pkt_avail), 32'h0);
    chk("rst_data", data_out, 32'h0);
    chk("rst_err", {29'd0, err_ovf, err_udf, parity_err}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk_on = 1'b1;

    // One packet fills VC0, then a fifth write overflows.
    cyc(1, 0, mk(T_HDR, 28'h1), 0, 0);
    cyc(1, 0, mk(T_PAY, 28'h2), 0, 0);
    cyc(1, 0, mk(T_PAY, 28'h3), 0, 0);
    cyc(1, 0, mk(T_TAIL, 28'h4), 0, 0);
    chk("full_ready", 32'(ready_out), 32'h2);
    chk("full_pkt", 32'(pkt_avail), 32'h1);
    chk("full_head", data_out, mk(T_HDR, 28'h1));
    cyc(1, 0, mk(T_PAY, 28'h5), 0, 0);
    chk("ovf_flag", 32'(err_ovf), 32'h1);
    chk("vc1_empty", 32'(empty[1]), 32'h1);

    // Full VC0 with simultaneous write and read: read wins, write dropped.
    cyc(1, 0, mk(T_PAY, 28'h6), 1, 0);
    chk("fullrw_ready", 32'(ready_out), 32'h3);
    chk("fullrw_head", data_out, mk(T_PAY, 28'h2));
    cyc(0, 0, '0, 1, 0);
    cyc(0, 0, '0, 1, 0);
    chk("pre_tail_pkt", 32'(pkt_avail), 32'h1);
    cyc(0, 0, '0, 1, 0);
    chk("tail_pop_pkt", 32'(pkt_avail), 32'h0);
    chk("drained", 32'(empty), 32'h3);

    // Empty VC0 with simultaneous write and read: write wins, read flagged.
    cyc(1, 0, mk(T_HDR, 28'h10), 1, 0);
    chk("emptyrw_empty", 32'(empty), 32'h2);
    chk("udf_flag", 32'(err_udf), 32'h1);

    // Writes to both VCs while presenting VC1 only.
    for (int i = 0; i < 4; i++)
      cyc(1, i % 2, mk(T_PAY, 28'(32 + i)), 0, 1);
    chk("vc1_head", data_out, mk(T_PAY, 28'd33));

    // Sustained push/pop on both VCs, wrapping pointers several times.
    for (int i = 0; i < 16; i++)
      cyc(1, i % 2, mk((i % 3 == 2) ? T_TAIL : T_PAY, 28'(64 + i)), 1, i % 2);
    for (int i = 0; i < 7; i++)
      cyc(0, 0, '0, 1, i % 2);

    // Odd-parity flit on VC1: stored in either build, flagged only with the check enabled.
    cyc(1, 1, 32'h0000_0001, 0, 1);
    chk("par_stored", data_out, 32'h0000_0001);
`ifdef PARITY_CHECK_EN
    chk("par_flag", 32'(parity_err), 32'h1);
`else
    chk("par_flag", 32'(parity_err), 32'h0);
`endif
    cyc(0, 0, '0, 1, 1);

    // Asynchronous reset in the middle of a packet.
    cyc(1, 0, mk(T_HDR, 28'h99), 0, 0);
    cyc(1, 0, mk(T_TAIL, 28'h9A), 0, 0);
    wr_en = 0;
    #2 rst = 1'b1;
    model_reset();
    #1;
    chk("arst_empty", 32'(empty), 32'h3);
    chk("arst_ready", 32'(ready_out), 32'h3);
    chk("arst_pkt", 32'(pkt_avail), 32'h0);
    chk("arst_data", data_out, 32'h0);
    chk("arst_err", {29'd0, err_ovf, err_udf, parity_err}, 32'h0);
    cyc(0, 0, '0, 0, 0);
    rst = 1'b0;
    cyc(1, 1, mk(T_TAIL, 28'h7), 0, 1);
    cyc(0, 0, '0, 1, 1);
    cyc(0, 0, '0, 0, 0);

    chk_on = 1'b0;
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
